// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between two writeback
//   requesters: A (ALU path) and B (multi-cycle load/mul path). Each cycle a
//   winner is picked round-robin; a winner may optionally lock the port for a
//   bounded burst of back-to-back writes. The winning address/data are
//   registered into the write-port pipeline stage one cycle after the grant.
//
// Ports
//   CLK              clock, rising edge
//   RST              asynchronous reset, active-low
//   Stall            register file busy; no grant while high
//   ReqA/ReqB        requester has a write pending
//   LockA/LockB      requester wants to keep ownership after this grant
//   AddrA/AddrB      destination register (AW bits)
//   DataA/DataB      write data (DW bits)
//   GntA/GntB        combinational grant; transfer accepted this cycle
//   Sel              external 2:1 address mux select (0 = AddrA, 1 = AddrB)
//   WE/WAddr/WData   registered write to the register file
//   dbg_state        current arbiter state (0 = IDLE, 1 = LOCK_A, 2 = LOCK_B)
//
// Handshake: Req acts as valid and Gnt as ready. A transfer happens in any
// cycle where Req and Gnt are both high; the requester holds Req, Lock, Addr
// and Data stable until it sees Gnt. Gnt depends only on state, Last, Stall,
// Req and reset, never on the downstream write stage.

module wb_port_arbiter #(
  parameter int DW       = 16,
  parameter int AW       = 3,
  parameter int MAXBURST = 4,
  parameter int CW       = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Stall,
  input  logic          ReqA,
  input  logic          LockA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] DataA,
  output logic          GntA,
  input  logic          ReqB,
  input  logic          LockB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DataB,
  output logic          GntB,
  output logic          Sel,
  output logic          WE,
  output logic [AW-1:0] WAddr,
  output logic [DW-1:0] WData,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  // A burst is complete once the grant being taken is the MAXBURST-th one,
  // i.e. when the count of grants already taken equals MAXBURST-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXBURST - 1);
  // With MAXBURST = 1 a single grant already exhausts the burst, so the lock
  // state is never entered.
  localparam bit CAN_LOCK = (MAXBURST > 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;   // 0 = A won most recently, 1 = B
  logic          gnt_a;
  logic          gnt_b;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (RST && !Stall) begin
      case (state)
        IDLE: begin
          if (ReqA && ReqB) begin
            // Conflict goes to the side that did not win last time.
            gnt_a = last;
            gnt_b = !last;
          end else begin
            gnt_a = ReqA;
            gnt_b = ReqB;
          end
        end
        LOCK_A:  gnt_a = ReqA;
        LOCK_B:  gnt_b = ReqB;
        default: ;
      endcase
    end
  end

  assign GntA      = gnt_a;
  assign GntB      = gnt_b;
  assign Sel       = gnt_b;
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      WE    <= 1'b0;
      WAddr <= '0;
      WData <= '0;
    end else begin
      WE <= gnt_a || gnt_b;
      if (gnt_a) begin
        WAddr <= AddrA;
        WData <= DataA;
        last  <= 1'b0;
      end else if (gnt_b) begin
        WAddr <= AddrB;
        WData <= DataB;
        last  <= 1'b1;
      end

      // A stalled cycle freezes state and count.
      if (!Stall) begin
        case (state)
          IDLE: begin
            if (gnt_a && LockA && CAN_LOCK) begin
              state <= LOCK_A;
              cnt   <= CW'(1);
            end else if (gnt_b && LockB && CAN_LOCK) begin
              state <= LOCK_B;
              cnt   <= CW'(1);
            end
          end
          LOCK_A: begin
            if (gnt_a) begin
              if (LockA && (cnt < CNT_LAST)) begin
                cnt <= cnt + 1'b1;
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end else if (!ReqA && !LockA) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          LOCK_B: begin
            if (gnt_b) begin
              if (LockB && (cnt < CNT_LAST)) begin
                cnt <= cnt + 1'b1;
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end else if (!ReqB && !LockB) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter. Each cycle the bench drives inputs,
//   checks the combinational grants against hand-computed values, and queues
//   the write it expects to see on the registered port one cycle later.

module tb_wb_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic          Stall = 1'b0;
  logic          ReqA = 1'b0, LockA = 1'b0;
  logic [AW-1:0] AddrA = '0;
  logic [DW-1:0] DataA = '0;
  logic          ReqB = 1'b0, LockB = 1'b0;
  logic [AW-1:0] AddrB = '0;
  logic [DW-1:0] DataB = '0;
  logic          GntA, GntB, Sel, WE;
  logic [AW-1:0] WAddr;
  logic [DW-1:0] WData;
  logic [1:0]    dbg_state;

  wb_port_arbiter #(.DW(DW), .AW(AW), .MAXBURST(4), .CW(3)) dut (
    .CLK(CLK), .RST(RST), .Stall(Stall),
    .ReqA(ReqA), .LockA(LockA), .AddrA(AddrA), .DataA(DataA), .GntA(GntA),
    .ReqB(ReqB), .LockB(LockB), .AddrB(AddrB), .DataB(DataB), .GntB(GntB),
    .Sel(Sel), .WE(WE), .WAddr(WAddr), .WData(WData), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check grants/Sel for the inputs currently driven and queue the write.
  task automatic expect_gnt(input string tag, input bit ea, input bit eb);
    check({tag, "_gnta"}, 32'(GntA), 32'(ea));
    check({tag, "_gntb"}, 32'(GntB), 32'(eb));
    check({tag, "_sel"},  32'(Sel),  32'(eb));
    if (ea) exp_q.push_back({AddrA, DataA});
    else if (eb) exp_q.push_back({AddrB, DataB});
  endtask

  // Advance one clock and check the registered write port.
  task automatic tick(input string tag);
    logic [AW+DW-1:0] w;
    @(posedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check({tag, "_we"},    32'(WE),    32'd1);
      check({tag, "_waddr"}, 32'(WAddr), 32'(w[AW+DW-1:DW]));
      check({tag, "_wdata"}, 32'(WData), 32'(w[DW-1:0]));
    end else begin
      check({tag, "_we"}, 32'(WE), 32'd0);
    end
  endtask

  task automatic cyc(input string tag, input bit ea, input bit eb);
    #1;
    expect_gnt(tag, ea, eb);
    tick(tag);
  endtask

  task automatic drive(input bit ra, input bit la, input bit rb, input bit lb);
    ReqA  = ra;
    LockA = la;
    ReqB  = rb;
    LockB = lb;
    AddrA = AW'($urandom_range(0, 7));
    DataA = DW'($urandom_range(0, 16'hFFFF));
    AddrB = AW'($urandom_range(0, 7));
    DataB = DW'($urandom_range(0, 16'hFFFF));
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    // 1: reset holds everything off even with both requesting
    drive(1, 0, 1, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_gnta",  32'(GntA),  32'd0);
    check("rst_gntb",  32'(GntB),  32'd0);
    check("rst_sel",   32'(Sel),   32'd0);
    check("rst_we",    32'(WE),    32'd0);
    check("rst_waddr", 32'(WAddr), 32'd0);
    check("rst_wdata", 32'(WData), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    RST = 1'b1;
    cyc("rst_first", 1, 0);            // Last = B after reset, so A wins

    // 2: single requester B
    drive(0, 0, 1, 0);
    AddrB = 3'd5;
    DataB = 16'h00AB;
    cyc("single_b", 0, 1);

    // 3: round-robin, no lock
    drive(1, 0, 1, 0); cyc("rr0", 1, 0);
    drive(1, 0, 1, 0); cyc("rr1", 0, 1);
    drive(1, 0, 1, 0); cyc("rr2", 1, 0);
    drive(1, 0, 1, 0); cyc("rr3", 0, 1);

    // 4: A locks for a 4-grant burst, then B gets the port
    drive(1, 1, 1, 0); cyc("burst0", 1, 0);
    check("burst_state", 32'(dbg_state), 32'd1);
    for (int i = 1; i < 4; i++) begin
      drive(1, 1, 1, 0); cyc($sformatf("burst%0d", i), 1, 0);
    end
    drive(1, 1, 1, 0); cyc("burst_end_b", 0, 1);

    // 5: stall for two cycles after the 2nd locked grant
    drive(1, 1, 1, 0); cyc("stl_a0", 1, 0);
    drive(1, 1, 1, 0); cyc("stl_a1", 1, 0);
    Stall = 1'b1;
    drive(1, 1, 1, 0); cyc("stl_0", 0, 0);
    drive(1, 1, 1, 0); cyc("stl_1", 0, 0);
    check("stl_state", 32'(dbg_state), 32'd1);
    Stall = 1'b0;
    drive(1, 1, 1, 0); cyc("stl_a2", 1, 0);
    drive(1, 1, 1, 0); cyc("stl_a3", 1, 0);
    drive(1, 1, 1, 0); cyc("stl_b", 0, 1);

    // Lock held with A idle ignores B; dropping Lock releases with no grant
    drive(1, 1, 0, 0); cyc("hold_a", 1, 0);
    drive(0, 1, 1, 0); cyc("hold_ign_b", 0, 0);
    drive(0, 0, 1, 0); cyc("release", 0, 0);
    check("release_state", 32'(dbg_state), 32'd0);
    drive(0, 0, 1, 0); cyc("after_rel_b", 0, 1);

    // 6: asynchronous reset in the middle of a B burst
    drive(0, 0, 1, 1); cyc("lb0", 0, 1);
    check("lb_state", 32'(dbg_state), 32'd2);
    drive(0, 0, 1, 1);
    #1;
    expect_gnt("lb1", 0, 1);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    exp_q.delete();                    // in-flight write is dropped
    check("arst_we",    32'(WE),    32'd0);
    check("arst_waddr", 32'(WAddr), 32'd0);
    check("arst_wdata", 32'(WData), 32'd0);
    check("arst_gntb",  32'(GntB),  32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    #1;
    RST = 1'b1;
    drive(1, 0, 1, 0); cyc("arst_a", 1, 0);
    drive(1, 0, 1, 0); cyc("arst_b", 0, 1);

    drive(0, 0, 0, 0); cyc("drain0", 0, 0);
    drive(0, 0, 0, 0); cyc("drain1", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
